// File: rtl/fishingrod_pkg.sv
// Shared types and constants for the Fishingrod round sequencer.
package fishingrod_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int NR_DEFAULT = 25;
    localparam int CPR        = 4;

    // Bit positions inside sels/selk; index 0 is the MSB of the bus.
    localparam int SEL_SWAP = 0;
    localparam int SEL_R9   = 1;
    localparam int SEL_R10  = 2;
    localparam int SEL_R11  = 3;
    localparam int SELK_RC  = 2;
    localparam int SELK_SB  = 3;

endpackage

// File: rtl/fishingrod_if.sv
// Host-side handshake bundle: input pair, result and status.
interface fishingrod_if;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_pt;
    logic [15:0] in_key;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_ct;
    logic        busy;

    modport master (
        output abort, in_valid, in_pt, in_key, out_ready,
        input  in_ready, out_valid, out_ct, busy
    );

    modport slave (
        input  abort, in_valid, in_pt, in_key, out_ready,
        output in_ready, out_valid, out_ct, busy
    );
endinterface

// File: rtl/fishingrod_sel_dec.sv
// Combinational decode of (state, phase) into the datapath sels/selk buses.
module fishingrod_sel_dec
    import fishingrod_pkg::*;
(
    input  state_e     state_s,
    input  logic [1:0] phase_s,
    output logic [0:4] sels_s,
    output logic [0:4] selk_s
);

    // Select schedule, only active while rounds are running
    always_comb begin
        sels_s = 5'b00000;
        selk_s = 5'b00000;
        if (state_s == RUN) begin
            sels_s[SEL_SWAP] = (phase_s == 2'd3);
            sels_s[SEL_R9]   = (phase_s == 2'd1);
            sels_s[SEL_R10]  = (phase_s == 2'd2);
            sels_s[SEL_R11]  = (phase_s == 2'd3);
            selk_s[0]        = phase_s[1];
            selk_s[1]        = phase_s[0];
            selk_s[SELK_RC]  = (phase_s == 2'd0);
            selk_s[SELK_SB]  = (phase_s == 2'd3);
        end else begin
            sels_s = 5'b00000;
            selk_s = 5'b00000;
        end
    end

endmodule

// File: rtl/fishingrod_ctrl.sv
// Sequencer for the byte-serial Fishingrod datapath: accepts a pt/key pair,
// steps NR rounds of CPR cycles, and returns the captured ciphertext.
module fishingrod_ctrl
    import fishingrod_pkg::*;
#(
    parameter int NR  = NR_DEFAULT,
    parameter int CPR = fishingrod_pkg::CPR
) (
    input  logic        ck,
    input  logic        rst,
    fishingrod_if.slave host,
    output logic [15:0] dp_inp,
    output logic [15:0] dp_key,
    output logic        dp_round0,
    output logic [4:0]  dp_round,
    output logic [0:4]  dp_sels,
    output logic [0:4]  dp_selk,
    input  logic [15:0] dp_out
);

    localparam logic [4:0] NR_W    = 5'(NR);
    localparam logic [1:0] PH_LAST = 2'(CPR - 1);

    state_e      state_r, state_s;
    logic [1:0]  phase_r, phase_s;
    logic [4:0]  round_r, round_s;
    logic [15:0] pt_r, pt_s;
    logic [15:0] key_r, key_s;
    logic [15:0] out_ct_r;
    logic        out_valid_r;
    logic        busy_r;
    logic        accept_s;
    logic        capture_s;
    logic [15:0] dp_inp_r, dp_key_r;
    logic        dp_round0_r;
    logic [4:0]  dp_round_r;
    logic [0:4]  dp_sels_r, dp_selk_r;
    logic [0:4]  sels_s, selk_s;

    // Acceptance is only possible from IDLE and never while abort or reset is high.
    assign host.in_ready  = (state_r == IDLE) & ~host.abort & ~rst;
    assign host.out_valid = out_valid_r;
    assign host.out_ct    = out_ct_r;
    assign host.busy      = busy_r;

    assign dp_inp    = dp_inp_r;
    assign dp_key    = dp_key_r;
    assign dp_round0 = dp_round0_r;
    assign dp_round  = dp_round_r;
    assign dp_sels   = dp_sels_r;
    assign dp_selk   = dp_selk_r;

    // Next-state logic; abort overrides every state
    always_comb begin
        state_s   = state_r;
        phase_s   = phase_r;
        round_s   = round_r;
        accept_s  = 1'b0;
        capture_s = 1'b0;
        if (host.abort) begin
            state_s = IDLE;
            phase_s = 2'd0;
            round_s = 5'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (host.in_valid && host.in_ready) begin
                        accept_s = 1'b1;
                        state_s  = LOAD;
                    end else begin
                        state_s = IDLE;
                    end
                end
                LOAD: begin
                    state_s = RUN;
                    round_s = 5'd1;
                    phase_s = 2'd0;
                end
                RUN: begin
                    phase_s = phase_r + 2'd1;
                    if (phase_r == PH_LAST) begin
                        if (round_r == NR_W) begin
                            capture_s = 1'b1;
                            state_s   = DONE;
                            phase_s   = 2'd0;
                            round_s   = 5'd0;
                        end else begin
                            round_s = round_r + 5'd1;
                        end
                    end else begin
                        round_s = round_r;
                    end
                end
                DONE: begin
                    if (host.out_ready) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DONE;
                    end
                end
                default: begin
                    state_s = IDLE;
                    phase_s = 2'd0;
                    round_s = 5'd0;
                end
            endcase
        end
    end

    // Operand holding registers are only loaded on acceptance
    always_comb begin
        pt_s  = pt_r;
        key_s = key_r;
        if (accept_s) begin
            pt_s  = host.in_pt;
            key_s = host.in_key;
        end else begin
            pt_s  = pt_r;
            key_s = key_r;
        end
    end

    fishingrod_sel_dec u_sel_dec (
        .state_s (state_s),
        .phase_s (phase_s),
        .sels_s  (sels_s),
        .selk_s  (selk_s)
    );

    // State, operands and datapath controls; dp_* decode the next state so they align with it
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            phase_r     <= 2'd0;
            round_r     <= 5'd0;
            pt_r        <= 16'h0000;
            key_r       <= 16'h0000;
            out_ct_r    <= 16'h0000;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            dp_inp_r    <= 16'h0000;
            dp_key_r    <= 16'h0000;
            dp_round0_r <= 1'b0;
            dp_round_r  <= 5'd0;
            dp_sels_r   <= 5'b00000;
            dp_selk_r   <= 5'b00000;
        end else begin
            state_r     <= state_s;
            phase_r     <= phase_s;
            round_r     <= round_s;
            pt_r        <= pt_s;
            key_r       <= key_s;
            if (capture_s) begin
                out_ct_r <= dp_out;
            end
            out_valid_r <= (state_s == DONE);
            busy_r      <= (state_s == LOAD) || (state_s == RUN);
            dp_inp_r    <= (state_s == LOAD) ? pt_s  : 16'h0000;
            dp_key_r    <= (state_s == LOAD) ? key_s : 16'h0000;
            dp_round0_r <= (state_s == LOAD);
            dp_round_r  <= (state_s == RUN) ? round_s : 5'd0;
            dp_sels_r   <= sels_s;
            dp_selk_r   <= selk_s;
        end
    end

endmodule

// File: doc/fishingrod_ctrl.md
Name: fishingrod_ctrl

Overview:
- Sequencer for the byte-serial Fishingrod round datapath (fishingrod_comb).
- Accepts one plaintext/key pair over a valid/ready handshake, then drives round0, round, sels and selk for NR rounds of CPR cycles each.
- Captures the datapath output on the final round cycle and presents it over a valid/ready output handshake.
- Sits between the host/bus interface and fishingrod_comb; it is the only driver of the datapath control inputs.

Parameters:
- NR, 25, number of rounds. Legal range 1..31; it must fit the 5-bit round field.
- CPR, 4, cycles per round. Fixed at 4; the select schedule below is defined only for 4.

Ports:
- ck  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- abort  input  1  cancels any operation; the FSM returns to IDLE on the next edge.
- in_valid  input  1  a plaintext/key pair is offered.
- in_ready  output  1  the block can accept a pair.
- in_pt  input  16  plaintext.
- in_key  input  16  key.
- out_valid  output  1  the result is valid.
- out_ready  input  1  the consumer accepts the result.
- out_ct  output  16  ciphertext result.
- busy  output  1  high in LOAD or RUN.
- dp_inp  output  16  to datapath inp.
- dp_key  output  16  to datapath key.
- dp_round0  output  1  to datapath round0.
- dp_round  output  5  to datapath round.
- dp_sels  output  5  to datapath sels.
- dp_selk  output  5  to datapath selk.
- dp_out  input  16  from datapath out.

Behaviour:
- Reset values, all outputs: in_ready=0 during reset, then 1 in IDLE; out_valid=0; out_ct=0; busy=0; dp_* all 0. The pt, key, round and phase registers all reset to 0.
- FSM states:
  - IDLE: in_ready = ~abort. If in_valid & in_ready, latch in_pt and in_key, go to LOAD.
  - LOAD: exactly 1 cycle. dp_round0=1, dp_inp=pt_q, dp_key=key_q, dp_round=0, dp_sels=0, dp_selk=0. Next state is RUN with round=1, phase=0.
  - RUN: dp_round0=0, dp_round=round. phase increments 0..3.
    - At phase 3, round increments.
    - At phase 3 with round==NR: capture dp_out into out_ct and go to DONE.
  - DONE: out_valid=1 and out_ct held stable. When out_ready=1, go to IDLE. out_valid drops on that edge.
- Select schedule in RUN, by phase (sels/selk bit 0 is the MSB):
  - dp_sels[0]=1 at phase 3.
  - dp_sels[1]=1 at phase 1.
  - dp_sels[2]=1 at phase 2.
  - dp_sels[3]=1 at phase 3.
  - dp_sels[4]=0 always.
  - dp_selk[0:1]=phase[1:0].
  - dp_selk[2]=1 at phase 0 (round constant injection).
  - dp_selk[3]=1 at phase 3.
  - dp_selk[4]=0 always.
- All dp_* outputs are registered decodes of state, phase and round. No combinational path from any input to dp_*.
- Latency: acceptance edge E. LOAD occupies cycle E+1. RUN occupies NR*CPR cycles. out_valid rises after edge E+1+NR*CPR, i.e. edge 101 for the defaults.
- out_ct changes only on the capture edge or on reset.
- in_ready=0 in LOAD, RUN and DONE. A new pair is accepted only from IDLE, so back-to-back throughput is one block per NR*CPR+3 cycles minimum.
- abort:
  - Highest priority in every state. On the next edge: go to IDLE, out_valid=0, dp_*=0, round=0, phase=0.
  - out_ct is not cleared.
  - abort together with in_valid in IDLE: the pair is not accepted.
- Reset asserted mid-operation: all registers clear immediately (asynchronous). The first accept is possible on the first edge after deassertion.
- out_ready while not in DONE is ignored. in_valid while in_ready=0 is ignored; the block does not sample in_pt/in_key.
- round never wraps: RUN always exits at round==NR.

Decomposition:
- fishingrod_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DONE);
  - NR_DEFAULT=25 and CPR=4;
  - sels/selk bit-index constants (SEL_SWAP=0, SEL_R9=1, SEL_R10=2, SEL_R11=3, SELK_RC=2, SELK_SB=3).
- One sub-module, fishingrod_sel_dec: a combinational decode of (state, phase) to sels/selk, registered in the parent.

Test Plan:
- Reset, then pt=16'h1234, key=16'hABCD.
  - LOAD cycle shows dp_round0=1, dp_inp=16'h1234, dp_key=16'hABCD.
  - out_valid rises exactly 101 edges after acceptance.
  - out_ct equals dp_out as sampled on the capture edge.
- Schedule check over a full run:
  - per round, dp_sels = 5'b00000, 01000, 00100, 10010 for phases 0..3;
  - dp_selk = 5'b00100, 01000, 10000, 11010 for phases 0..3;
  - dp_round steps 1..25.
- Output backpressure: hold out_ready=0 for 20 cycles after out_valid. out_valid and out_ct stay stable and in_ready stays 0. Assert out_ready for one cycle: state returns to IDLE and in_ready=1 on the next cycle.
- abort at round 7, phase 2: next edge shows IDLE, dp_* all 0, out_valid=0. A following pair is accepted and completes normally in 101 cycles.
- abort and in_valid both high in IDLE: in_ready=0 and no LOAD occurs. Deassert abort: accepted on the next edge.
- Asynchronous rst pulse mid-RUN (not clock-aligned): outputs go to reset values immediately. After release, the next pair completes with nominal latency.
